truth_table_sweeper: RTL and testbench

- Synchronous stimulus/response stage wrapped around a 4-input combinational logic block (e.g. the path-delayed AND4 cell).
- Upstream side: drives the block's inputs m,n,p,q through all 2^N_IN input combinations, holding each for a programmable number of cycles so path delays settle.
- Downstream side: samples the block's single output once per vector and assembles a truth-table signature.
- Replaces free-running testbench loops with a reusable, start/done-controlled hardware sequencer.

---
 rtl/truth_table_sweeper.sv | 139 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Start/done controlled sequencer that sweeps every input vector of a small
// combinational block and assembles its truth-table signature.
module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int HOLD_CYCLES   = 19,
  parameter int SAMPLE_OFFSET = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   resp,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   signature
);

  localparam int NVEC = 1 << N_IN;
  localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0]   SAMPLE_AT = CW'(SAMPLE_OFFSET);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   HOLD_ZERO = CW'(0);
  localparam logic [CW-1:0]   HOLD_ONE  = CW'(1);
  localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(NVEC - 1);
  localparam logic [N_IN-1:0] IDX_ZERO  = N_IN'(0);
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [NVEC-1:0] SIG_ZERO  = NVEC'(0);

  // Reject parameter sets the sequencer cannot honour.
  if (N_IN < 1 || HOLD_CYCLES < 1 || SAMPLE_OFFSET < 0 || SAMPLE_OFFSET >= HOLD_CYCLES) begin : g_bad_params
    $error("truth_table_sweeper: need N_IN>=1, HOLD_CYCLES>=1, 0<=SAMPLE_OFFSET<HOLD_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     hold_q, hold_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NVEC-1:0]   sig_q, sig_d;

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: begin
        vec_d  = IDX_ZERO;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_DRIVE;
          busy_d  = 1'b1;
          idx_d   = IDX_ZERO;
          hold_d  = HOLD_ZERO;
          sig_d   = SIG_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        hold_d = hold_q + HOLD_ONE;
        // Sampling precedes the advance so a coincident sample lands on the old index.
        if (hold_q == SAMPLE_AT) begin
          sig_d[idx_q] = resp;
        end else begin
          sig_d = sig_q;
        end
        if (hold_q == HOLD_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hold_d  = HOLD_ZERO;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            vec_d  = idx_q + IDX_ONE;
            hold_d = HOLD_ZERO;
          end
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        vec_d   = IDX_ZERO;
        idx_d   = IDX_ZERO;
        hold_d  = HOLD_ZERO;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        vec_d   = IDX_ZERO;
        idx_d   = IDX_ZERO;
        hold_d  = HOLD_ZERO;
        sig_d   = SIG_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_ZERO;
      hold_q  <= HOLD_ZERO;
      vec_q   <= IDX_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SIG_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench: a delayed truth-table block drives resp; the expected
// signature comes from the sample instant of each vector and the response delay.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start2;
  logic        resp;
  logic        resp2;
  logic [3:0]  vec;
  logic [3:0]  vec2;
  logic        busy;
  logic        busy2;
  logic        done;
  logic        done2;
  logic [15:0] signature;
  logic [15:0] sig2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] tt;
  int          dly;
  logic [3:0]  hist [0:31];

  truth_table_sweeper u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .resp      (resp),
    .vec       (vec),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(1), .SAMPLE_OFFSET(0)) u_fast (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .resp      (resp2),
    .vec       (vec2),
    .busy      (busy2),
    .done      (done2),
    .signature (sig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block under test for the main instance: table lookup seen dly cycles late.
  always @(posedge clk) begin
    hist[1] <= vec;
    for (int j = 2; j < 32; j++) hist[j] <= hist[j-1];
  end
  always_comb resp = (dly == 0) ? tt[vec] : tt[hist[dly]];

  // OR4 block for the fast instance.
  always_comb resp2 = |vec2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bit i = table value of whatever vector was on the bus d cycles before
  // the sample instant of vector i (vec is 0 before the sweep starts).
  function automatic logic [15:0] exp_sig(input logic [15:0] t, input int d,
                                          input int hold, input int so);
    logic [15:0] r;
    int s;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      s = i * hold + so - d;
      r[i] = (s < 0) ? t[0] : t[s / hold];
    end
    return r;
  endfunction

  // mode 0: plain sweep; 1: extra starts while busy and in FINISH; 2: reset at vec==7
  task automatic do_sweep(input logic [15:0] t, input int d, input int mode);
    logic [15:0] e;
    tt = t;
    dly = d;
    e = exp_sig(t, d, 19, 16);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sig_cleared", {16'h0, signature}, 32'h0);
    for (int k = 1; k <= 304; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      chk("vec_drive", {28'h0, vec}, (k - 1) / 19);
      chk("busy_drive", {31'h0, busy}, 32'd1);
      chk("done_drive", {31'h0, done}, 32'd0);
      if (mode == 1) start = (k == 99);
      if (mode == 2 && k == 7 * 19 + 6) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_vec", {28'h0, vec}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_sig", {16'h0, signature}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          chk("rst_nodone", {31'h0, done}, 32'd0);
          chk("rst_idle", {31'h0, busy}, 32'd0);
        end
        return;
      end
    end
    @(posedge clk); #1;
    start = (mode == 1);
    chk("done_pulse", {31'h0, done}, 32'd1);
    chk("busy_finish", {31'h0, busy}, 32'd0);
    chk("vec_finish", {28'h0, vec}, 32'd15);
    chk("signature", {16'h0, signature}, {16'h0, e});
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_end", {31'h0, done}, 32'd0);
    chk("busy_end", {31'h0, busy}, 32'd0);
    chk("vec_idle", {28'h0, vec}, 32'd0);
    chk("sig_hold", {16'h0, signature}, {16'h0, e});
    if (mode == 1) begin
      for (int j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        chk("no_restart_busy", {31'h0, busy}, 32'd0);
        chk("no_second_done", {31'h0, done}, 32'd0);
        chk("sig_stable", {16'h0, signature}, {16'h0, e});
      end
    end
  endtask

  task automatic idle_gap(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fast_sweep();
    logic [15:0] t;
    logic [15:0] e;
    t = 16'hFFFE;
    e = exp_sig(t, 0, 1, 0);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      chk("fast_vec", {28'h0, vec2}, k - 1);
      chk("fast_busy", {31'h0, busy2}, 32'd1);
      chk("fast_done_early", {31'h0, done2}, 32'd0);
    end
    @(posedge clk); #1;
    chk("fast_done", {31'h0, done2}, 32'd1);
    chk("fast_sig", {16'h0, sig2}, {16'h0, e});
    chk("fast_vec_finish", {28'h0, vec2}, 32'd15);
    @(posedge clk); #1;
    chk("fast_done_end", {31'h0, done2}, 32'd0);
    chk("fast_vec_idle", {28'h0, vec2}, 32'd0);
  endtask

  initial begin
    logic [15:0] t;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    tt     = 16'h8000;
    dly    = 0;
    idle_gap(35);
    chk("reset_vec", {28'h0, vec}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_sig", {16'h0, signature}, 32'd0);
    chk("reset_sig_fast", {16'h0, sig2}, 32'd0);
    rst = 1'b0;
    idle_gap(3);

    // AND4 block, then AND4 behind a 15-cycle pipeline, then stale sampling
    do_sweep(16'h8000, 0, 0);
    idle_gap(40);
    do_sweep(16'h8000, 15, 0);
    idle_gap(40);
    do_sweep(16'h8000, 17, 0);
    idle_gap(40);
    do_sweep(16'h8000, 25, 0);
    idle_gap(40);

    for (int r = 0; r < 4; r++) begin
      t = 16'($urandom);
      do_sweep(t, $urandom_range(16, 0), 0);
      idle_gap(40);
    end

    t = 16'($urandom);
    do_sweep(t, 3, 1);
    idle_gap(5);
    do_sweep(16'($urandom), 5, 2);
    do_sweep(t, 3, 0);

    // back-to-back: start sits in the first IDLE cycle after done
    do_sweep(t, 16, 0);
    do_sweep(t, 16, 0);
    idle_gap(5);

    fast_sweep();
    idle_gap(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
